vector_output_capture: RTL
==========================

# vector_output_capture

Parametrised output-capture unit between the CPU's vector result port (`out`/`outFlag`) and a lane-serial host/trace interface. Every `outFlag` pulse captures one full vector into a FIFO, so back-to-back outputs are never lost while the consumer stalls. A serializer FSM drains each captured vector one lane per beat over a valid/ready handshake. Per-entry scalar mode emits lane 0 only. Saturating counters report captures and drops.

## Interface
- `DATA_WIDTH`, 19: lane width in bits.
- `VECTOR_SIZE`, 6: lanes per vector, ≥2.
- `DEPTH`, 8: FIFO entries, power of two, ≥2.
- `CNT_WIDTH`, 16: width of the status counters.
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `out`  in  VECTOR_SIZE*DATA_WIDTH  CPU vector result; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `outFlag`  in  1  capture request, sampled each rising edge.
- `scalarMode`  in  1  sampled with `outFlag`, stored per entry; 1 = emit lane 0 only.
- `laneData`  out  DATA_WIDTH  current lane value.
- `laneValid`  out  1  `laneData` is valid.
- `laneReady`  in  1  consumer accepts the beat.
- `laneIndex`  out  $clog2(VECTOR_SIZE)  lane number of the current beat.
- `lastLane`  out  1  current beat is the final beat of its vector.
- `full`, `empty`  out  1 each  FIFO status.
- `captureCount`, `dropCount`  out  CNT_WIDTH each  saturating counters.

## Operation
- Reset values: `laneValid`=0, `laneData`=0, `laneIndex`=0, `lastLane`=0, `full`=0, `empty`=1, both counters 0. FSM enters IDLE. FIFO pointers clear and all stored entries are discarded.
- Push: when `outFlag` is 1 and the FIFO has room, store {`scalarMode`, `out`} and increment `captureCount`.
- The FIFO has room when `full`=0, or when `full`=1 and a pop occurs on the same edge. In the pop-while-full case the occupancy is unchanged.
- Drop: when `outFlag` is 1 and the FIFO has no room, discard the vector and increment `dropCount`.
- Both counters saturate at all-ones.
- FSM states: IDLE and SEND.
  - IDLE: if `empty`=0, pop the head into the shift register, set `laneIndex`=0 and go to SEND.
  - SEND: `laneValid`=1. A beat transfers on an edge where `laneValid` and `laneReady` are both 1.
  - SEND, non-final beat: on transfer, advance `laneIndex` and `laneData`.
  - SEND, final beat: on transfer, pop the next entry directly if the FIFO is non-empty (no bubble) and stay in SEND; otherwise go to IDLE.
- Final beat: `laneIndex`=VECTOR_SIZE-1 in vector mode, or `laneIndex`=0 in scalar mode.
- `lastLane` = `laneValid` and the current beat is the final beat.
- While `laneValid`=1 and `laneReady`=0, `laneData`, `laneIndex` and `lastLane` hold stable.
- Lanes are emitted in order, lane 0 first.

## Timing
- `outFlag` sampled at edge E → `empty` falls after E → entry popped at edge E+1 → `laneValid` high after E+1.
- Capture-to-first-beat latency is 2 edges when the serializer is idle.
- Throughput is one lane per cycle with `laneReady` held at 1.
- A vector-mode entry occupies VECTOR_SIZE beats; a scalar-mode entry occupies 1 beat.
- Consecutive entries stream with no idle cycle between them.
- `full`/`empty` are registered and reflect occupancy after the edge.
- A push and a pop on the same edge are both honoured.
- Reset asserted mid-stream takes effect at that edge:
  - the in-flight vector is abandoned;
  - `laneValid` is 0 in the next cycle;
  - pending entries are lost;
  - `outFlag` on the reset edge is ignored.

## Structure
- Package `vector_out_pkg`:
  - `lane_t` (logic [DATA_WIDTH-1:0]);
  - `capture_entry_t` struct {scalarMode, lanes[VECTOR_SIZE]};
  - `ser_state_t` enum {IDLE, SEND}.
- Sub-module `sync_fifo`: parametrised by width and depth; push, pop, full, empty; synchronous active-high reset.
- Top level: the FSM, the lane shift register and the saturating counters.

## Test plan
- Single capture, `out` lanes 1..6, `laneReady`=1 → beats 1,2,3,4,5,6 on consecutive cycles starting 2 edges after capture; `lastLane` only on value 6; `captureCount`=1.
- Backpressure: `laneReady` low for 3 cycles during lane 2 → `laneData`=3 and `laneIndex`=2 held; the sequence resumes with no lane lost or duplicated.
- Overflow with `DEPTH`=4 and `laneReady`=0: 7 consecutive `outFlag` pulses → `full`=1; `captureCount`=5 (4 stored + 1 in the shift register); `dropCount`=2.
- Scalar mode: capture {7,8,9,10,11,12} with `scalarMode`=1, then a vector-mode capture → first beat 7 with `lastLane`=1, followed immediately by 6 lanes of the second vector.
- Pop-while-full: FIFO full, final beat transferring, `outFlag`=1 on the same edge → vector stored, `full` stays 1, `dropCount` unchanged.
- Reset mid-vector at lane 3 → the next cycle shows `laneValid`=0, `empty`=1 and both counters 0; the next capture is emitted normally.

Source files
------------

// File: rtl/vector_out_pkg.sv
// Shared types and default parameters for the vector output-capture slice.
package vector_out_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 19;
  localparam int unsigned DEF_VECTOR_SIZE = 6;
  localparam int unsigned DEF_DEPTH       = 8;
  localparam int unsigned DEF_CNT_WIDTH   = 16;

  typedef logic [DEF_DATA_WIDTH-1:0] lane_t;

  typedef struct packed {
    logic                              scalarMode;
    lane_t [DEF_VECTOR_SIZE-1:0]       lanes;
  } capture_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/vector_output_capture.sv
// Captures CPU vector results into a FIFO and serialises them lane by lane
// over a valid/ready interface, with saturating capture/drop counters.
module vector_output_capture
  import vector_out_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned VECTOR_SIZE = DEF_VECTOR_SIZE,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] out,
  input  logic                              outFlag,
  input  logic                              scalarMode,
  output logic [DATA_WIDTH-1:0]             laneData,
  output logic                              laneValid,
  input  logic                              laneReady,
  output logic [$clog2(VECTOR_SIZE)-1:0]    laneIndex,
  output logic                              lastLane,
  output logic                              full,
  output logic                              empty,
  output logic [CNT_WIDTH-1:0]              captureCount,
  output logic [CNT_WIDTH-1:0]              dropCount
);

  localparam int unsigned IW = $clog2(VECTOR_SIZE);
  localparam int unsigned VW = VECTOR_SIZE * DATA_WIDTH;
  localparam int unsigned EW = 1 + VW;
  localparam logic [IW-1:0] LAST_IDX = IW'(VECTOR_SIZE - 1);

  logic [EW-1:0] head;
  logic          fifo_full, fifo_empty;
  logic          push, pop, room, xfer, final_beat;

  ser_state_t     state_q, state_d;
  logic [VW-1:0]  lanes_q, lanes_d;
  logic           scalar_q, scalar_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cap_q, cap_d, drop_q, drop_d;

  // A pop on this edge frees a slot, so a full FIFO can still accept the push.
  assign room = !fifo_full || pop;
  assign push = outFlag && room;

  sync_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({scalarMode, out}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign laneValid  = (state_q == SEND);
  assign xfer       = laneValid && laneReady;
  assign final_beat = scalar_q ? (idx_q == '0) : (idx_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    lanes_d  = lanes_q;
    scalar_d = scalar_q;
    idx_d    = idx_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      SEND: begin
        if (xfer) begin
          if (final_beat) begin
            if (!fifo_empty) pop = 1'b1;
            else             state_d = IDLE;
          end else begin
            lanes_d = lanes_q >> DATA_WIDTH;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      lanes_d  = head[VW-1:0];
      scalar_d = head[EW-1];
      idx_d    = '0;
      state_d  = SEND;
    end
  end

  always_comb begin
    cap_d  = cap_q;
    drop_d = drop_q;
    if (push && (cap_q != '1))               cap_d  = cap_q + 1'b1;
    if (outFlag && !room && (drop_q != '1))  drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      lanes_q  <= '0;
      scalar_q <= 1'b0;
      idx_q    <= '0;
      cap_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      lanes_q  <= lanes_d;
      scalar_q <= scalar_d;
      idx_q    <= idx_d;
      cap_q    <= cap_d;
      drop_q   <= drop_d;
    end
  end

  assign laneData     = lanes_q[DATA_WIDTH-1:0];
  assign laneIndex    = idx_q;
  assign lastLane     = laneValid && final_beat;
  assign full         = fifo_full;
  assign empty        = fifo_empty;
  assign captureCount = cap_q;
  assign dropCount    = drop_q;

endmodule
